gp_regfile_mp: RTL and testbench
================================

// Module: gp_regfile_mp
// PURPOSE
//  Parametrised multi-port general-purpose register file for the MIPS pipeline ID stage.
//  - N combinational read ports and M synchronous write ports.
//  - Optional write-to-read bypass, so WB writes are visible to ID in the same cycle.
//  - Optional hardwired-zero register 0.
//  - Sequential clear sweep: zeroes the array without asserting reset_n.
// PARAMETERS
//  DATA_W   32  register width in bits
//  ADDR_W   5   address width; DEPTH = 2**ADDR_W registers
//  NUM_RD   2   read ports (1..4)
//  NUM_WR   1   write ports (1..2); a higher port index has higher priority
//  ZERO_REG 1   1: register 0 reads 0 and writes to it are discarded
//  BYPASS   1   1: a read of an address being written this cycle returns that write's data
// PORTS
//  clk          in   1               clock; all state updates on rising edge
//  reset_n      in   1               asynchronous, active-low reset
//  clr_req      in   1               pulse: start a clear sweep (ignored while clr_busy)
//  clr_busy     out  1               clear sweep in progress
//  we           in   NUM_WR          per-port write enable
//  waddr        in   NUM_WR*ADDR_W   write addresses; port k occupies [k*ADDR_W +: ADDR_W]
//  wdata        in   NUM_WR*DATA_W   write data, packed the same way
//  re           in   NUM_RD          per-port read enable
//  raddr        in   NUM_RD*ADDR_W   read addresses, packed
//  rdata        out  NUM_RD*DATA_W   read data, packed, combinational
//  wr_conflict  out  1               registered one-cycle pulse: 2+ ports wrote the same address
// BEHAVIOUR
//  Reset: async, when reset_n=0.
//  - All DEPTH registers <= 0.
//  - FSM <= IDLE; clr_busy=0; wr_conflict=0.
//  - rdata therefore reads 0.
//  Writes:
//  - Port k with we[k]=1 writes wdata[k] to waddr[k] on the rising edge.
//  - Same address on several ports: the highest index wins; wr_conflict=1 the next cycle only.
//  - ZERO_REG=1: a write to address 0 is dropped, and a drop alone never raises wr_conflict.
//  Reads:
//  - Latency 0 (combinational).
//  - re[j]=0 -> rdata[j]=0.
//  - ZERO_REG=1 and raddr[j]=0 -> rdata[j]=0.
//  - BYPASS=1: if any enabled write port targets raddr[j] (and the address is not a dropped
//    address 0), rdata[j] = wdata of the highest-index such port. Otherwise rdata[j] = array value.
//  - BYPASS=0: rdata[j] is always the array value; the new value is visible the cycle after the write.
//  Clear FSM (states IDLE, SWEEP):
//  - IDLE, clr_req=1 -> SWEEP with cnt=0; clr_busy rises on the next edge.
//  - SWEEP: each cycle reg[cnt] <= 0 and cnt <= cnt+1.
//    At cnt=DEPTH-1, clear that register and return to IDLE. The sweep lasts DEPTH cycles exactly.
//  - While in SWEEP:
//    - we is ignored and the writes are lost (no conflict pulse).
//    - rdata is forced to 0 on all ports.
//    - clr_req is ignored.
//  - The cycle clr_req is sampled in IDLE, that cycle's write still completes normally.
//  - reset_n low mid-sweep aborts the sweep immediately: FSM=IDLE and the full array is zero.
//  - cnt is ADDR_W wide; DEPTH-1 is the terminal count, so cnt does not wrap past it.
//  Width rules: no truncation; all addresses are in range by construction.
// STRUCTURE
//  - Package regfile_pkg:
//    - default DATA_W/ADDR_W;
//    - clr_state_t enum {IDLE, SWEEP};
//    - ZERO_ADDR constant.
//  - Sub-module regfile_clr_fsm:
//    - inputs clk, reset_n, clr_req;
//    - outputs clr_busy, clr_we, clr_addr.
//  - The top module holds the array, the write-priority/conflict logic, and generate loops over the read ports.
// TESTING
//  1. Reset, then read r0..r31 on both ports -> all 0, clr_busy=0, wr_conflict=0.
//  2. Write port0 r5=0xDEADBEEF; same cycle re0 raddr0=5:
//     - BYPASS=1 -> 0xDEADBEEF that cycle;
//     - BYPASS=0 -> 0 that cycle, 0xDEADBEEF the next cycle.
//  3. NUM_WR=2, same cycle port0 r7=0x11111111 and port1 r7=0x22222222:
//     - r7 reads 0x22222222;
//     - wr_conflict=1 for exactly one cycle.
//  4. Write r0=0x12345678 -> r0 reads 0 and wr_conflict stays 0 (ZERO_REG=1).
//  5. Fill r1..r31 with address value (r1=1, r2=2, ...), then pulse clr_req:
//     - clr_busy high for exactly 32 cycles;
//     - a write of r3=0xAA mid-sweep is lost;
//     - afterwards all registers read 0.
//  6. Start a sweep, assert reset_n=0 at sweep cycle 10:
//     - clr_busy drops asynchronously;
//     - all registers read 0;
//     - after release, a new clr_req starts a fresh 32-cycle sweep.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port general-purpose register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_ADDR  = 0;

  typedef enum logic {
    IDLE,
    SWEEP
  } clr_state_t;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear-sweep sequencer: walks every register address once and zeroes one register per cycle.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  clr_state_t        state, state_next;
  logic [ADDR_W-1:0] cnt, cnt_next;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every output of this block is defaulted first so no path leaves a latch behind.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_next = SWEEP;
          cnt_next   = '0;
        end
      end
      SWEEP: begin
        if (cnt == '1) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign clr_busy = (state == SWEEP);
  assign clr_we   = clr_busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/gp_regfile_mp.sv
// Multi-port register file with write priority, conflict flag, optional bypass and zero register.
module gp_regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr_req,
  output logic                     clr_busy,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     wr_conflict
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [DATA_W-1:0] wd [NUM_WR];
  logic [NUM_WR-1:0] wr_ok;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              conflict_now;

  regfile_clr_fsm #(.ADDR_W(ADDR_W)) u_clr_fsm (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A write "counts" only if enabled and not aimed at the hardwired zero register.
  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
    assign wa[k]    = waddr[k*ADDR_W +: ADDR_W];
    assign wd[k]    = wdata[k*DATA_W +: DATA_W];
    assign wr_ok[k] = we[k] && !((ZERO_REG != 0) && (wa[k] == ADDR_W'(ZERO_ADDR)));
  end

  // NOTE: the array takes the async reset so reset_n alone guarantees an all-zero file.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      // Later ports overwrite earlier ones, giving the highest index priority.
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_ok[k]) mem[wa[k]] <= wd[k];
      end
    end
  end

  always_comb begin
    conflict_now = 1'b0;
    for (int k = 0; k < NUM_WR; k++) begin
      for (int l = k + 1; l < NUM_WR; l++) begin
        if (wr_ok[k] && wr_ok[l] && (wa[k] == wa[l])) conflict_now = 1'b1;
      end
    end
    if (clr_busy) conflict_now = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wr_conflict <= 1'b0;
    else          wr_conflict <= conflict_now;
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    assign ra = raddr[j*ADDR_W +: ADDR_W];

    always_comb begin
      rv = mem[ra];
      if (BYPASS != 0) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_ok[k] && (wa[k] == ra)) rv = wd[k];
        end
      end
      if (clr_busy || !re[j] || ((ZERO_REG != 0) && (ra == ADDR_W'(ZERO_ADDR)))) rv = '0;
    end

    assign rdata[j*DATA_W +: DATA_W] = rv;
  end

endmodule

// File: tb/tb_gp_regfile_mp.sv
// Self-checking bench for gp_regfile_mp (2 read, 2 write ports, zero register, bypass on).
module tb_gp_regfile_mp;

  logic        clk;
  logic        reset_n;
  logic        clr_req;
  logic        clr_busy;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic        wr_conflict;

  int checks = 0;
  int errors = 0;

  // Reference model: plain register contents plus "sweep cycles still to run".
  logic [31:0] mdl [32];
  int          sweep_left;
  logic        exp_conf;

  gp_regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clr_req     (clr_req),
    .clr_busy    (clr_busy),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .re          (re),
    .raddr       (raddr),
    .rdata       (rdata),
    .wr_conflict (wr_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input int j);
    logic [4:0] a;
    a = raddr[j*5 +: 5];
    if (sweep_left > 0 || !re[j] || a == 5'd0) return 32'h0;
    for (int k = 1; k >= 0; k--) begin
      if (we[k] && waddr[k*5 +: 5] == a) return wdata[k*32 +: 32];
    end
    return mdl[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    sweep_left = 0;
    exp_conf   = 1'b0;
  endtask

  // Applies the clock edge that just happened to the model, using the inputs held over it.
  task automatic model_edge();
    if (sweep_left > 0) begin
      sweep_left--;
      exp_conf = 1'b0;
    end else begin
      exp_conf = (we == 2'b11) && (waddr[4:0] == waddr[9:5]) && (waddr[4:0] != 5'd0);
      for (int k = 0; k < 2; k++) begin
        if (we[k] && waddr[k*5 +: 5] != 5'd0) mdl[waddr[k*5 +: 5]] = wdata[k*32 +: 32];
      end
      if (clr_req) begin
        sweep_left = 32;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      end
    end
  endtask

  // Inputs are set just after a falling edge; outputs are compared mid-low-phase.
  task automatic tick();
    #2;
    check("rd0", {32'h0, rdata[31:0]},  {32'h0, exp_rd(0)});
    check("rd1", {32'h0, rdata[63:32]}, {32'h0, exp_rd(1)});
    check("busy", {63'h0, clr_busy}, {63'h0, (sweep_left > 0)});
    check("conflict", {63'h0, wr_conflict}, {63'h0, exp_conf});
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    we = 2'b00; waddr = '0; wdata = '0; clr_req = 1'b0;
  endtask

  task automatic read_all();
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      re    = 2'b11;
      raddr = {5'(i + 16), 5'(i)};
      tick();
    end
  endtask

  task automatic count_sweep(input string tag, input int reset_at);
    int busy_cycles;
    busy_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      idle_inputs();
      if (c == 5) begin we = 2'b01; waddr[4:0] = 5'd3; wdata[31:0] = 32'hAA; end
      if (c == 8) clr_req = 1'b1;
      re = 2'b01; raddr = {5'd0, 5'd3};
      #1;
      if (!clr_busy || c == reset_at) break;
      busy_cycles++;
      tick();
    end
    idle_inputs();
    if (reset_at < 0) check(tag, 64'(busy_cycles), 64'd32);
    else              check(tag, 64'(busy_cycles), 64'(reset_at));
  endtask

  initial begin
    reset_n = 1'b0;
    re      = 2'b00;
    raddr   = '0;
    idle_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", {63'h0, clr_busy}, 64'h0);
    check("reset_conflict", {63'h0, wr_conflict}, 64'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state: every register reads zero on both ports.
    read_all();

    // Same-cycle bypass of a write, then array value next cycle.
    we = 2'b01; waddr[4:0] = 5'd5; wdata[31:0] = 32'hDEADBEEF;
    re = 2'b01; raddr[4:0] = 5'd5;
    #1 check("bypass_r5", {32'h0, rdata[31:0]}, 64'hDEADBEEF);
    tick();
    idle_inputs();
    #1 check("array_r5", {32'h0, rdata[31:0]}, 64'hDEADBEEF);
    tick();

    // Two ports writing r7: port 1 wins, one-cycle conflict pulse.
    we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22222222, 32'h11111111};
    re = 2'b01; raddr = {5'd0, 5'd7};
    #1 check("bypass_r7", {32'h0, rdata[31:0]}, 64'h22222222);
    tick();
    idle_inputs();
    #1 check("conflict_pulse", {63'h0, wr_conflict}, 64'h1);
    check("array_r7", {32'h0, rdata[31:0]}, 64'h22222222);
    tick();
    #1 check("conflict_drop", {63'h0, wr_conflict}, 64'h0);
    tick();

    // Writes to r0 (even from both ports) are dropped and raise no conflict.
    we = 2'b11; waddr = '0; wdata = {32'h12345678, 32'h12345678};
    re = 2'b11; raddr = '0;
    #1 check("r0_bypass", rdata, 64'h0);
    tick();
    idle_inputs();
    #1 check("r0_conflict", {63'h0, wr_conflict}, 64'h0);
    check("r0_array", rdata, 64'h0);
    tick();

    // Fill r1..r31 with their own address, then sweep; mid-sweep write and clr_req are lost.
    for (int i = 1; i < 32; i++) begin
      we = 2'b01; waddr[4:0] = 5'(i); wdata[31:0] = 32'(i);
      re = 2'b10; raddr[9:5] = 5'(i - 1);
      tick();
    end
    idle_inputs();
    clr_req = 1'b1;
    tick();
    count_sweep("sweep_len", -1);
    read_all();

    // Sweep aborted by reset at sweep cycle 10; unswept registers must also be zero.
    for (int i = 16; i < 32; i++) begin
      we = 2'b01; waddr[4:0] = 5'(i); wdata[31:0] = 32'hA500 + 32'(i);
      tick();
    end
    idle_inputs();
    clr_req = 1'b1;
    tick();
    count_sweep("sweep_abort_at", 10);
    re = 2'b11; raddr = {5'd20, 5'd31};
    reset_n = 1'b0;
    #1 check("abort_busy", {63'h0, clr_busy}, 64'h0);
    check("abort_rdata", rdata, 64'h0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    read_all();
    clr_req = 1'b1;
    tick();
    count_sweep("sweep_after_reset", -1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      we      = 2'($urandom);
      waddr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wdata   = {32'($urandom), 32'($urandom)};
      re      = 2'($urandom);
      raddr   = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 9))};
      clr_req = ($urandom_range(0, 59) == 0);
      tick();
    end
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
